mult_seq_par: RTL
=================

Name: mult_seq_par

Overview:
- Parametrised sequential multiplier with even-parity protection; successor to the fixed 16-bit req/ack parity multiplier.
- Adds a configurable operand width and a configurable number of bits retired per cycle.
- Adds a per-request signed/unsigned mode, an explicit FSM and a busy indicator.
- Sits behind the req/ack argument interface and drives the result_rdy result interface consumed by the result monitor.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH. Legal range 4..32.
- STEP, 1, operand bits consumed per CALC cycle; must divide WIDTH.
- N (localparam), WIDTH/STEP, number of CALC cycles.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- arg_a  in  WIDTH  operand A.
- arg_a_parity  in  1  even-parity bit for arg_a.
- arg_b  in  WIDTH  operand B.
- arg_b_parity  in  1  even-parity bit for arg_b.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the arguments.
- req  in  1  arguments valid.
- ack  out  1  one-cycle pulse: arguments captured.
- busy  out  1  high in every state except IDLE.
- result  out  2*WIDTH  product.
- result_parity  out  1  XOR of all result bits.
- result_rdy  out  1  one-cycle pulse: result valid.
- arg_parity_error  out  1  valid with result_rdy; 1 if either operand failed parity.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- While rst_n=0: state=IDLE; ack, busy, result, result_parity, result_rdy and arg_parity_error are all 0; internal registers are cleared.
- All outputs are registered.
- FSM states: IDLE, CHECK, CALC, DONE.
- IDLE:
  - On a posedge with req=1, capture arg_a, arg_b, both parity bits and signed_mode; go to CHECK.
  - req is sampled only in IDLE and is ignored in every other state.
- CHECK (one cycle):
  - ack=1 and busy=1 for this cycle only.
  - Parity error = (^arg_a != arg_a_parity) or (^arg_b != arg_b_parity).
  - On error: result=0, result_parity=0, arg_parity_error=1; go to DONE.
  - Otherwise: form magnitudes (abs value if signed_mode=1 and MSB=1), record neg = signed_mode & (a_msb ^ b_msb), clear the accumulator and the counter; go to CALC.
- CALC (exactly N cycles):
  - Each cycle adds (|A| × the next STEP bits of |B|), shifted, into the accumulator, LSB-first.
  - After cycle N, result = neg ? -acc : acc, truncated to 2*WIDTH; go to DONE.
- DONE (one cycle):
  - result_rdy=1; result, result_parity and arg_parity_error are valid.
  - Next state is IDLE.
  - result and flags hold their values until the next CHECK or reset.
- Latency, with ack high in cycle c:
  - Normal request: result_rdy in cycle c+N+1.
  - Parity error: result_rdy in cycle c+1.
- Boundary conditions:
  - Width: -2^(WIDTH-1) × -2^(WIDTH-1) = 2^(2*WIDTH-2) must be exact; magnitudes are held in WIDTH bits unsigned and the accumulator in 2*WIDTH bits.
  - Zero operand: normal latency, result 0, parity 0.
  - req held high through DONE: a second capture occurs on the first IDLE posedge, so consecutive acks are at least N+3 cycles apart.
  - rst_n falling mid-operation: the operation is discarded, no result_rdy is emitted, and outputs clear immediately.
  - req=1 at the same time as rst_n deassertion: sampled on the first posedge after rst_n=1.

Decomposition:
- mult_pkg (shared) holds:
  - typedef enum for mult_state_t {IDLE, CHECK, CALC, DONE};
  - function even_parity (reduction XOR);
  - default WIDTH/STEP constants.
- Sub-module mult_shift_add_unit: magnitude accumulator plus STEP-bit partial-product adder, controlled by load/step/finish inputs from the FSM.

Test Plan (WIDTH=16, STEP=1 unless stated):
1. Signed mode: a=3 (parity 0), b=-2 (0xFFFE, parity 1) -> result 0xFFFFFFFA, result_parity 0, arg_parity_error 0, result_rdy exactly 17 cycles after ack.
2. a=1 with arg_a_parity 0, b=5 with correct parity -> arg_parity_error 1, result 0, result_parity 0, result_rdy 1 cycle after ack, CALC never entered.
3. Signed mode: a=b=0x8000 (parity 1 each) -> result 0x40000000, result_parity 1, no error.
4. Unsigned mode: a=b=0xFFFF (parity 0) -> result 0xFFFE0001, result_parity 0; the same inputs in signed mode -> 0x00000001, parity 1.
5. rst_n low for 2 cycles starting 5 cycles after ack -> no result_rdy, all outputs 0, busy 0; next request 7×9 -> 63 with normal latency.
6. STEP=4 build, req held high continuously with 100×(-3) -> result 0xFFFFFED4, result_rdy 5 cycles after each ack, acks spaced exactly 7 cycles apart.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM states, parity helper and default sizing for mult_seq_par
package mult_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STEP = 1;
  typedef enum logic [1:0] {IDLE, CHECK, CALC, DONE} mult_state_t;
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/mult_shift_add_unit.sv
// mult_shift_add_unit: magnitude shift-add accumulator; load clears and seeds, step retires STEP bits of b, finish latches the signed product (ports: clk, rst_n, load, step, finish, neg, a_mag, b_mag -> prod, prod_parity)
module mult_shift_add_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               neg,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] prod,
  output logic               prod_parity
);
  logic [2*WIDTH-1:0] a_sh, acc, pp, acc_nxt, res;
  logic [WIDTH-1:0]   b_sh;
  logic               neg_q;
  always_comb begin
    pp      = a_sh * {{(2*WIDTH-STEP){1'b0}}, b_sh[STEP-1:0]};
    acc_nxt = acc + pp;
    res     = neg_q ? -acc_nxt : acc_nxt;
  end
  // finish coincides with the last step, so the product is taken from acc_nxt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh        <= '0;
      b_sh        <= '0;
      acc         <= '0;
      neg_q       <= 1'b0;
      prod        <= '0;
      prod_parity <= 1'b0;
    end else if (load) begin
      a_sh        <= {{WIDTH{1'b0}}, a_mag};
      b_sh        <= b_mag;
      acc         <= '0;
      neg_q       <= neg;
      prod        <= '0;
      prod_parity <= 1'b0;
    end else if (step) begin
      acc  <= acc_nxt;
      a_sh <= a_sh << STEP;
      b_sh <= b_sh >> STEP;
      if (finish) begin
        prod        <= res;
        prod_parity <= even_parity(64'(res));
      end
    end
  end
endmodule

// File: rtl/mult_seq_par.sv
// mult_seq_par: parity-checked sequential signed/unsigned multiplier with req/ack input and result_rdy output (ports: clk, rst_n, arg_a/arg_b with parity, signed_mode, req -> ack, busy, result, result_parity, result_rdy, arg_parity_error)
module mult_seq_par
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP  = DEF_STEP
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   arg_a,
  input  logic               arg_a_parity,
  input  logic [WIDTH-1:0]   arg_b,
  input  logic               arg_b_parity,
  input  logic               signed_mode,
  input  logic               req,
  output logic               ack,
  output logic               busy,
  output logic [2*WIDTH-1:0] result,
  output logic               result_parity,
  output logic               result_rdy,
  output logic               arg_parity_error
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = $clog2(N) + 1;
  mult_state_t      state, nxt;
  logic [WIDTH-1:0] a_q, b_q, a_mag, b_mag;
  logic             pa_q, pb_q, sm_q, err, neg, last;
  logic             ack_d, busy_d, rdy_d;
  logic [CW-1:0]    cnt;
  always_comb begin
    err   = (even_parity(64'(a_q)) != pa_q) || (even_parity(64'(b_q)) != pb_q);
    a_mag = (sm_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag = (sm_q && b_q[WIDTH-1]) ? -b_q : b_q;
    neg   = sm_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    last  = (cnt == CW'(N - 1));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ack        <= 1'b0;
      busy       <= 1'b0;
      result_rdy <= 1'b0;
    end else begin
      state      <= nxt;
      ack        <= ack_d;
      busy       <= busy_d;
      result_rdy <= rdy_d;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = req ? CHECK : IDLE;
      CHECK:   nxt = err ? DONE : CALC;
      CALC:    nxt = last ? DONE : CALC;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // outputs are decoded from the next state so their registers line up with the state they describe
  always_comb begin
    ack_d  = (nxt == CHECK);
    busy_d = (nxt != IDLE);
    rdy_d  = (nxt == DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q              <= '0;
      b_q              <= '0;
      pa_q             <= 1'b0;
      pb_q             <= 1'b0;
      sm_q             <= 1'b0;
      cnt              <= '0;
      arg_parity_error <= 1'b0;
    end else begin
      if (state == IDLE && req) begin
        a_q  <= arg_a;
        b_q  <= arg_b;
        pa_q <= arg_a_parity;
        pb_q <= arg_b_parity;
        sm_q <= signed_mode;
      end
      if (state == CHECK) begin
        cnt              <= '0;
        arg_parity_error <= err;
      end else if (state == CALC) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
  // load also fires on a parity error, which clears the product to zero
  mult_shift_add_unit #(.WIDTH(WIDTH), .STEP(STEP)) u_unit (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (state == CHECK),
    .step        (state == CALC),
    .finish      (state == CALC && last),
    .neg         (neg),
    .a_mag       (a_mag),
    .b_mag       (b_mag),
    .prod        (result),
    .prod_parity (result_parity)
  );
endmodule
